// File: rtl/regfile_mp.sv
// Multi-port integer register file with a pending-write scoreboard and a post-reset scrub.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic                conflict_q, conflict_d;

  // Scrub walk, write ports in priority order, scoreboard and collision detect.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    regs_d     = regs_q;
    busy_d     = busy_q;
    conflict_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        regs_d[ptr_q] = '0;
        ptr_d         = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        // Ascending order lets the highest-index port overwrite lower ones.
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
            regs_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
            busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
          end else begin
            conflict_d = conflict_d;
          end
        end
        for (int j = 0; j < NUM_WR; j++) begin
          for (int k = j + 1; k < NUM_WR; k++) begin
            if (wr_en[j] && wr_en[k] &&
                (wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W]) &&
                (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
              conflict_d = 1'b1;
            end else begin
              conflict_d = conflict_d;
            end
          end
        end
        // Issue marks after writeback clears so a simultaneous set wins.
        if (sb_set) begin
          busy_d[sb_addr] = 1'b1;
        end else begin
          busy_d = busy_d;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // Control state with synchronous reset; scrub restarts from entry 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      ptr_q      <= ADDR_W'(1);
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  // Storage array; contents are defined by the scrub, so no reset.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] hd;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = rd_addr[i*ADDR_W +: ADDR_W];
      hit = 1'b0;
      hd  = '0;
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
          hit = 1'b1;
          hd  = wr_data[j*DATA_W +: DATA_W];
        end else begin
          hit = hit;
        end
      end
`endif
      if ((state_q == ST_RUN) && rd_en[i] && (ra != '0)) begin
        rd_data[i*DATA_W +: DATA_W] = hit ? hd : regs_q[ra];
        rd_busy[i]                  = busy_q[ra] & ~hit;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]                  = 1'b0;
      end
    end
  end

  assign init_done   = (state_q == ST_RUN);
  assign wr_conflict = conflict_q;

endmodule
